// File: rtl/pio_pkg.sv
// rtl/pio_pkg.sv - register word addresses shared by the edge-capture PIO
package pio_pkg;

  localparam logic [2:0] ADDR_DATA = 3'd0;
  localparam logic [2:0] ADDR_RISE = 3'd1;
  localparam logic [2:0] ADDR_MASK = 3'd2;
  localparam logic [2:0] ADDR_CAP  = 3'd3;
  localparam logic [2:0] ADDR_FALL = 3'd4;
  localparam logic [2:0] ADDR_DBL  = 3'd5;

endpackage

// File: rtl/pio_debounce_ch.sv
// rtl/pio_debounce_ch.sv - one input channel: synchroniser plus optional debounce filter
// Debounce counter present only when PIO_DEBOUNCE_EN is defined.
module pio_debounce_ch #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                din,
  input  logic [DB_CNT_W-1:0] limit,
  input  logic                restart,
  output logic                dout
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

  assign sync = sync_q[SYNC_STAGES-1];

`ifdef PIO_DEBOUNCE_EN
  logic [DB_CNT_W-1:0] cnt;
  logic                filt;

  // A limit rewrite restarts any count in flight; the compare point stops the counter wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      filt <= 1'b0;
    end else if (restart) begin
      cnt <= '0;
    end else if (sync == filt) begin
      cnt <= '0;
    end else if (cnt == limit) begin
      filt <= sync;
      cnt  <= '0;
    end else begin
      cnt <= cnt + DB_CNT_W'(1);
    end
  end

  assign dout = filt;
`else
  logic unused_db;
  assign unused_db = ^{limit, restart};
  assign dout      = sync;
`endif

endmodule

// File: rtl/pio_edge_irq_v2.sv
// rtl/pio_edge_irq_v2.sv - Avalon-MM PIO with per-channel edge select, W1C capture and masked irq
// Define PIO_DEBOUNCE_EN to include the debounce counters and the DB_LIMIT register.
module pio_edge_irq_v2
  import pio_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter int               SYNC_STAGES = 2,
  parameter int               DB_CNT_W    = 16,
  parameter int               DB_RESET    = 50000,
  parameter logic [WIDTH-1:0] RISE_RESET  = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic             wr;
  logic [WIDTH-1:0] filt, filt_d, rise_en, fall_en, irq_mask, edge_cap;
  logic [WIDTH-1:0] ev, clr;
  logic [DB_CNT_W-1:0] db_limit;
  logic             db_restart;
  logic [31:0]      rd_mux;
  logic             unused_wd;

  assign wr        = chipselect & ~write_n;
  assign unused_wd = ^writedata;

`ifdef PIO_DEBOUNCE_EN
  assign db_restart = wr && (address == ADDR_DBL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           db_limit <= DB_CNT_W'(DB_RESET);
    else if (db_restart) db_limit <= writedata[DB_CNT_W-1:0];
  end
`else
  logic [DB_CNT_W-1:0] unused_dbr;
  assign unused_dbr = DB_CNT_W'(DB_RESET);
  assign db_restart = 1'b0;
  assign db_limit   = '0;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    pio_debounce_ch #(
      .SYNC_STAGES(SYNC_STAGES),
      .DB_CNT_W   (DB_CNT_W)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .din    (in_port[i]),
      .limit  (db_limit),
      .restart(db_restart),
      .dout   (filt[i])
    );
  end

  assign ev  = (filt & ~filt_d & rise_en) | (~filt & filt_d & fall_en);
  assign clr = (wr && (address == ADDR_CAP)) ? writedata[WIDTH-1:0] : '0;

  // New events are OR-ed in after the clear so a same-cycle edge is never lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_d   <= '0;
      rise_en  <= RISE_RESET;
      fall_en  <= '0;
      irq_mask <= '0;
      edge_cap <= '0;
    end else begin
      filt_d   <= filt;
      edge_cap <= (edge_cap & ~clr) | ev;
      if (wr && address == ADDR_RISE) rise_en  <= writedata[WIDTH-1:0];
      if (wr && address == ADDR_FALL) fall_en  <= writedata[WIDTH-1:0];
      if (wr && address == ADDR_MASK) irq_mask <= writedata[WIDTH-1:0];
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA: rd_mux[WIDTH-1:0] = filt;
      ADDR_RISE: rd_mux[WIDTH-1:0] = rise_en;
      ADDR_MASK: rd_mux[WIDTH-1:0] = irq_mask;
      ADDR_CAP:  rd_mux[WIDTH-1:0] = edge_cap;
      ADDR_FALL: rd_mux[WIDTH-1:0] = fall_en;
`ifdef PIO_DEBOUNCE_EN
      ADDR_DBL:  rd_mux[DB_CNT_W-1:0] = db_limit;
`endif
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) readdata <= '0;
    else       readdata <= rd_mux;
  end

  assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_pio_edge_irq_v2.sv
// tb/tb_pio_edge_irq_v2.sv - directed self-checking bench for pio_edge_irq_v2
// Covers both builds; PIO_DEBOUNCE_EN selects the debounce-specific vectors.
module tb_pio_edge_irq_v2;

`ifdef PIO_DEBOUNCE_EN
  localparam int LAT = 2 + 3 + 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  logic [31:0] rv;
  logic [31:0] exp_rst;

  pio_edge_irq_v2 dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .in_port   (in_port),
    .readdata  (readdata),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
    address = a;
    tick(1);
    d = readdata;
  endtask

  initial begin
    reset      = 1'b1;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = '0;
    tick(3);
    reset = 1'b0;
    tick(1);

    check("irq_reset", {31'd0, irq}, 32'd0);
    for (int a = 0; a < 8; a++) begin
      exp_rst = 32'd0;
      if (a == 1) exp_rst = 32'hF;
`ifdef PIO_DEBOUNCE_EN
      if (a == 5) exp_rst = 32'd50000;
`endif
      bus_rd(3'(a), rv);
      check($sformatf("reset_rd_%0d", a), rv, exp_rst);
    end

`ifdef PIO_DEBOUNCE_EN
    bus_wr(3'd5, 32'd3);
`endif

    // ch0 rising edge: DATA flips exactly LAT+1 edges after the drive.
    address    = 3'd0;
    in_port[0] = 1'b1;
    tick(LAT);
    check("data0_before", readdata, 32'h0);
    tick(1);
    check("data0_after", readdata, 32'h1);
    bus_rd(3'd3, rv);
    check("cap_ch0", rv, 32'h1);
    check("irq_masked", {31'd0, irq}, 32'd0);
    bus_wr(3'd2, 32'h1);
    check("irq_unmasked", {31'd0, irq}, 32'd1);
    bus_wr(3'd3, 32'h1);
    check("irq_cleared", {31'd0, irq}, 32'd0);

`ifdef PIO_DEBOUNCE_EN
    in_port[1] = 1'b1;
    tick(3);
    in_port[1] = 1'b0;
    tick(10);
    bus_rd(3'd0, rv);
    check("short_pulse_data", rv, 32'h1);
    bus_rd(3'd3, rv);
    check("short_pulse_cap", rv, 32'h0);
    in_port[1] = 1'b1;
    tick(4);
    in_port[1] = 1'b0;
    tick(12);
    bus_rd(3'd3, rv);
    check("long_pulse_cap", rv, 32'h2);
`else
    in_port[1] = 1'b1;
    tick(1);
    in_port[1] = 1'b0;
    tick(6);
    bus_rd(3'd3, rv);
    check("pulse_cap", rv, 32'h2);
`endif
    bus_wr(3'd3, 32'h2);

    // Falling-only selection on ch2.
    bus_wr(3'd1, 32'h0);
    bus_wr(3'd4, 32'h4);
    in_port[2] = 1'b1;
    tick(LAT + 4);
    bus_rd(3'd3, rv);
    check("ch2_rise_ignored", rv, 32'h0);
    in_port[2] = 1'b0;
    tick(LAT + 4);
    bus_rd(3'd3, rv);
    check("ch2_fall_cap", rv, 32'h4);
    bus_wr(3'd3, 32'h4);
    in_port[2] = 1'b1;
    tick(LAT + 4);
    bus_rd(3'd3, rv);
    check("ch2_rise_again", rv, 32'h0);

    // Partial W1C, then a clear colliding with a new ch1 edge.
    in_port[0] = 1'b0;
    tick(LAT + 4);
    bus_wr(3'd1, 32'h3);
    in_port[1:0] = 2'b11;
    tick(LAT + 4);
    bus_rd(3'd3, rv);
    check("cap_both", rv, 32'h3);
    check("irq_both", {31'd0, irq}, 32'd1);
    bus_wr(3'd3, 32'h1);
    check("irq_after_w1c", {31'd0, irq}, 32'd0);
    bus_rd(3'd3, rv);
    check("cap_partial_clr", rv, 32'h2);
    in_port[1] = 1'b0;
    tick(LAT + 4);
    in_port[1] = 1'b1;
    tick(LAT);
    bus_wr(3'd3, 32'h2);
    bus_rd(3'd3, rv);
    check("set_beats_clr", rv, 32'h2);

`ifdef PIO_DEBOUNCE_EN
    // Limit rewrite with the ch3 count at 2 restarts the count.
    bus_wr(3'd5, 32'd5);
    address    = 3'd0;
    in_port[3] = 1'b1;
    tick(4);
    bus_wr(3'd5, 32'd5);
    address = 3'd0;
    tick(6);
    check("restart_hold", readdata, 32'h7);
    tick(1);
    check("restart_done", readdata, 32'hF);
    bus_rd(3'd5, rv);
    check("dblimit_rd", rv, 32'd5);
`else
    bus_wr(3'd5, 32'h1234);
    bus_rd(3'd5, rv);
    check("addr5_reads0", rv, 32'h0);
`endif

    bus_wr(3'd6, 32'hFFFF_FFFF);
    bus_rd(3'd6, rv);
    check("reserved6", rv, 32'h0);
    bus_rd(3'd7, rv);
    check("reserved7", rv, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
